mac_vector_feeder: RTL and testbench
====================================

// Module: mac_vector_feeder
// PURPOSE
//  Upstream sequencer for the pipelined saturating MAC (4-stage multiplier).
//  Buffers one pair of length-N signed vectors from a valid/ready input
//  stream, clears the MAC, streams the pairs into it and counts its
//  valid_out pulses. It then presents the saturated dot product on a
//  valid/ready output stream. This gives one clean dot product per vector pair.
// PARAMETERS
//  WIDTH     14  element width (signed); MAC result is 2*WIDTH bits
//  N         8   vector length (elements per dot product), N>=1
//  CLR_WAIT  6   cycles held in CLEAR after the mac_reset pulse (covers the MAC's 5-cycle clear pipeline)
// PORTS
//  clk            in   1        clock
//  reset          in   1        synchronous, active-high reset
//  s_valid        in   1        input pair valid
//  s_ready        out  1        feeder accepts a pair
//  s_a, s_b       in   WIDTH    signed input elements a[i], b[i]
//  mac_a, mac_b   out  WIDTH    operands to MAC a/b
//  mac_valid_in   out  1        MAC valid_in
//  mac_reset      out  1        MAC reset (clears its accumulator)
//  mac_f          in   2*WIDTH  MAC accumulator f
//  mac_valid_out  in   1        MAC valid_out
//  m_valid        out  1        result valid
//  m_ready        in   1        downstream accepts result
//  m_data         out  2*WIDTH  signed dot-product result
// BEHAVIOUR
//  - Clocking: all state updates on the clk rising edge. Reset is synchronous and active-high.
//  - Reset: state=LOAD, wr_ptr=rd_ptr=cnt=0. All of the following are 0: s_ready,
//    mac_valid_in, m_valid, m_data, mac_a, mac_b. mac_reset=1 while reset is high.
//  - Buffer: two N-deep WIDTH arrays (a_mem, b_mem), indexed by pointers of width $clog2(N).
//  - LOAD: s_ready=1. On s_valid&s_ready, write s_a->a_mem[wr_ptr] and
//    s_b->b_mem[wr_ptr], then increment wr_ptr. The beat with wr_ptr==N-1 sets
//    wr_ptr=0 and moves to CLEAR. s_ready drops in the next cycle.
//  - CLEAR: mac_reset=1 for exactly the first cycle, then 0. A wait counter runs
//    for CLR_WAIT cycles, then the state moves to STREAM. mac_valid_in=0 throughout.
//  - STREAM: one element per cycle, with no gaps.
//    Drive mac_a=a_mem[rd_ptr], mac_b=b_mem[rd_ptr] and mac_valid_in=1, all registered outputs.
//    After N issues, set rd_ptr=0, deassert mac_valid_in and move to DRAIN.
//  - DRAIN: cnt counts mac_valid_out pulses. mac_valid_out can also arrive during
//    STREAM, and those pulses are counted too.
//    On the pulse that makes cnt==N, register m_data<=mac_f and set m_valid=1,
//    then move to OUTPUT.
//  - OUTPUT: m_valid and m_data are held stable until m_ready.
//    On m_valid&m_ready: m_valid=0, cnt=0, and the state moves to LOAD
//    (s_ready=1 in the next cycle). If m_ready was already high on entry,
//    the handshake completes in the first OUTPUT cycle.
//  - End-to-end latency: the last input beat to m_valid is ~1+CLR_WAIT+N+6 cycles.
//    This is set by the MAC pipeline. Only the handshakes are normative.
//  - Arithmetic: the feeder does no math. Saturation at +2^(2W-1)-1 and
//    -2^(2W-1) comes from the MAC. m_data is mac_f passed through unchanged.
//  - Boundaries:
//    - s_valid while not in LOAD is ignored (s_ready=0).
//    - N=1: CLEAR->STREAM (1 issue)->DRAIN (1 pulse) works.
//    - Stray mac_valid_out in LOAD or CLEAR is ignored.
//    - Reset mid-operation: return to LOAD immediately and discard any partial vector
//      and any pending result. m_valid=0 in the next cycle.
//    - Pointers wrap only at N, never at 2^ADDR_W.
// TESTING
//  1. N=4. a=[1,2,3,4], b=[5,6,7,8] sent back-to-back, m_ready=1 -> m_data=70,
//     one m_valid pulse, exactly 4 mac_valid_in cycles.
//  2. Two vector pairs in sequence, the second being a=[-1,-1,-1,-1], b=[3,3,3,3]
//     -> results 70 then -12. This proves the clear works between vectors (no
//     carry-over of 70).
//  3. Saturation: a=b=8191 and a=-8192, b=8191 repeated with N=8 ->
//     m_data stays within [-2^27, 2^27-1]. The expected value is checked with the
//     MAC's clamp rule.
//  4. Back-pressure: m_ready=0 for 10 cycles after m_valid -> m_data stable and
//     s_ready=0 throughout. On m_ready=1 -> LOAD with s_ready=1 in the next cycle.
//  5. Gapped input: s_valid toggled randomly, and s_valid asserted during STREAM ->
//     only N beats accepted, and the result matches the dot product of the accepted beats.
//  6. Reset asserted in the middle of STREAM -> mac_reset=1, m_valid=0, state LOAD.
//     A following vector gives the correct result with no residue.

Source files
------------

// File: rtl/mac_vector_feeder.sv
// Sequencer that buffers one pair of signed length-N vectors, clears the
// downstream saturating MAC, streams the element pairs into it, counts the
// MAC's result pulses and hands the final dot product out on a valid/ready port.
module mac_vector_feeder #(
  parameter int WIDTH    = 14,
  parameter int N        = 8,
  parameter int CLR_WAIT = 6
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 s_valid,
  output logic                 s_ready,
  input  logic [WIDTH-1:0]     s_a,
  input  logic [WIDTH-1:0]     s_b,
  output logic [WIDTH-1:0]     mac_a,
  output logic [WIDTH-1:0]     mac_b,
  output logic                 mac_valid_in,
  output logic                 mac_reset,
  input  logic [2*WIDTH-1:0]   mac_f,
  input  logic                 mac_valid_out,
  output logic                 m_valid,
  input  logic                 m_ready,
  output logic [2*WIDTH-1:0]   m_data
);

  localparam int ADDR_W = (N > 1) ? $clog2(N) : 1;
  localparam int CNT_W  = $clog2(N + 1);
  localparam int WAIT_W = (CLR_WAIT > 1) ? $clog2(CLR_WAIT) : 1;

  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(N - 1);
  localparam logic [CNT_W-1:0]  CNT_N     = CNT_W'(N);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(CLR_WAIT - 1);

  typedef enum logic [2:0] {
    LOAD   = 3'd0,
    CLEAR  = 3'd1,
    STREAM = 3'd2,
    DRAIN  = 3'd3,
    OUTPUT = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                s_ready_q, s_ready_d;
  logic [WIDTH-1:0]    mac_a_q, mac_a_d;
  logic [WIDTH-1:0]    mac_b_q, mac_b_d;
  logic                mac_valid_in_q, mac_valid_in_d;
  logic                m_valid_q, m_valid_d;
  logic [2*WIDTH-1:0]  m_data_q, m_data_d;
  logic                wr_en;
  logic                cnt_inc;

  logic [WIDTH-1:0]    a_mem [N];
  logic [WIDTH-1:0]    b_mem [N];

  // Next-state and datapath decisions for the five-phase sequence.
  always_comb begin
    // NOTE: every signal assigned here gets a default first so no path leaves it unassigned (no latches).
    state_d        = state_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    cnt_d          = cnt_q;
    wait_d         = wait_q;
    mac_a_d        = mac_a_q;
    mac_b_d        = mac_b_q;
    mac_valid_in_d = 1'b0;
    m_valid_d      = m_valid_q;
    m_data_d       = m_data_q;
    wr_en          = 1'b0;

    // MAC results may start arriving while elements are still being issued.
    cnt_inc = mac_valid_out && ((state_q == STREAM) || (state_q == DRAIN));
    if (cnt_inc) begin
      cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      LOAD: begin
        if (s_valid && s_ready_q) begin
          wr_en = 1'b1;
          if (wr_ptr_q == LAST_IDX) begin
            wr_ptr_d = '0;
            wait_d   = '0;
            state_d  = CLEAR;
          end else begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          end
        end
      end
      CLEAR: begin
        if (wait_q == WAIT_LAST) begin
          wait_d  = '0;
          state_d = STREAM;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      STREAM: begin
        mac_a_d        = a_mem[rd_ptr_q];
        mac_b_d        = b_mem[rd_ptr_q];
        mac_valid_in_d = 1'b1;
        if (rd_ptr_q == LAST_IDX) begin
          rd_ptr_d = '0;
          state_d  = DRAIN;
        end else begin
          rd_ptr_d = rd_ptr_q + ADDR_W'(1);
        end
      end
      DRAIN: begin
        if (cnt_d == CNT_N) begin
          m_data_d  = mac_f;
          m_valid_d = 1'b1;
          state_d   = OUTPUT;
        end
      end
      OUTPUT: begin
        if (m_ready) begin
          m_valid_d = 1'b0;
          cnt_d     = '0;
          state_d   = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase

    s_ready_d = (state_d == LOAD);
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    if (reset) begin
      state_q        <= LOAD;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      cnt_q          <= '0;
      wait_q         <= '0;
      s_ready_q      <= 1'b0;
      mac_a_q        <= '0;
      mac_b_q        <= '0;
      mac_valid_in_q <= 1'b0;
      m_valid_q      <= 1'b0;
      m_data_q       <= '0;
    end else begin
      state_q        <= state_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      cnt_q          <= cnt_d;
      wait_q         <= wait_d;
      s_ready_q      <= s_ready_d;
      mac_a_q        <= mac_a_d;
      mac_b_q        <= mac_b_d;
      mac_valid_in_q <= mac_valid_in_d;
      m_valid_q      <= m_valid_d;
      m_data_q       <= m_data_d;
    end
  end

  // Element buffer writes on each accepted input beat.
  always_ff @(posedge clk) begin
    // NOTE: the buffer is not reset; every entry is rewritten before STREAM reads it.
    if (wr_en) begin
      a_mem[wr_ptr_q] <= s_a;
      b_mem[wr_ptr_q] <= s_b;
    end
  end

  // The MAC is cleared while reset is held and in the first CLEAR cycle only.
  assign mac_reset    = reset || ((state_q == CLEAR) && (wait_q == '0));
  assign s_ready      = s_ready_q;
  assign mac_a        = mac_a_q;
  assign mac_b        = mac_b_q;
  assign mac_valid_in = mac_valid_in_q;
  assign m_valid      = m_valid_q;
  assign m_data       = m_data_q;

endmodule

// File: tb/tb_mac_vector_feeder.sv
// Bench for mac_vector_feeder: a behavioural saturating MAC (4-stage multiplier,
// then accumulate) sits on the feeder's MAC port; expected dot products are
// queued as vectors are sent and compared by a monitor at each result handshake.
module tb_mac_vector_feeder;

  localparam int WIDTH    = 14;
  localparam int N        = 4;
  localparam int CLR_WAIT = 6;
  localparam int FW       = 2 * WIDTH;
  localparam longint SAT_MAX = (longint'(1) << (FW - 1)) - 1;
  localparam longint SAT_MIN = -(longint'(1) << (FW - 1));

  typedef int vec_t [N];

  logic             clk;
  logic             reset;
  logic             s_valid;
  logic             s_ready;
  logic [WIDTH-1:0] s_a, s_b;
  logic [WIDTH-1:0] mac_a, mac_b;
  logic             mac_valid_in;
  logic             mac_reset;
  logic [FW-1:0]    mac_f;
  logic             mac_valid_out;
  logic             m_valid;
  logic             m_ready;
  logic [FW-1:0]    m_data;

  logic             model_vout;
  logic             stray;
  logic             pv [4];
  longint           pp [4];
  longint           acc;

  int     n_checks = 0;
  int     n_fail   = 0;
  longint exp_q [$];
  int     vin_cnt  = 0;

  mac_vector_feeder #(.WIDTH(WIDTH), .N(N), .CLR_WAIT(CLR_WAIT)) dut (
    .clk           (clk),
    .reset         (reset),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_a           (s_a),
    .s_b           (s_b),
    .mac_a         (mac_a),
    .mac_b         (mac_b),
    .mac_valid_in  (mac_valid_in),
    .mac_reset     (mac_reset),
    .mac_f         (mac_f),
    .mac_valid_out (mac_valid_out),
    .m_valid       (m_valid),
    .m_ready       (m_ready),
    .m_data        (m_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic longint sat(input longint v);
    if (v > SAT_MAX) return SAT_MAX;
    if (v < SAT_MIN) return SAT_MIN;
    return v;
  endfunction

  // Saturating dot product: the clamp is applied after every accumulation.
  function automatic longint ref_dot(input vec_t va, input vec_t vb);
    longint s = 0;
    for (int i = 0; i < N; i++) s = sat(s + longint'(va[i]) * longint'(vb[i]));
    return s;
  endfunction

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp_v, $time);
    end
  endtask

  // Behavioural MAC: product pipeline of 4 stages, then a saturating accumulator.
  assign mac_f         = FW'(acc);
  assign mac_valid_out = model_vout | stray;

  always @(posedge clk) begin
    if (mac_reset) begin
      for (int i = 0; i < 4; i++) pv[i] <= 1'b0;
      acc        <= 0;
      model_vout <= 1'b0;
    end else begin
      pv[0] <= mac_valid_in;
      pp[0] <= longint'($signed(mac_a)) * longint'($signed(mac_b));
      for (int i = 1; i < 4; i++) begin
        pv[i] <= pv[i-1];
        pp[i] <= pp[i-1];
      end
      if (pv[3]) acc <= sat(acc + pp[3]);
      model_vout <= pv[3];
    end
  end

  // Monitor: counts MAC issues and scores each result handshake.
  always @(negedge clk) begin
    #1;
    if (reset) begin
      vin_cnt = 0;
    end else begin
      if (mac_valid_in) vin_cnt++;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          check("result_expected", exp_q.size(), 1);
        end else begin
          longint exp_v;
          exp_v = exp_q.pop_front();
          check("m_data", $signed(m_data), exp_v);
          check("mac_valid_in_cycles", vin_cnt, N);
        end
        vin_cnt = 0;
      end
    end
  end

  // Drive one beat and hold it until the feeder takes it (bounded).
  task automatic drive_beat(input int a, input int b);
    int t = 0;
    s_a     = WIDTH'(a);
    s_b     = WIDTH'(b);
    s_valid = 1'b1;
    while (!s_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("beat_accepted_in_time", s_ready, 1);
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic send_vec(input vec_t va, input vec_t vb, input int max_gap,
                          input bit junk, input longint exp_v);
    // Stray MAC pulse while idle in LOAD must not be counted.
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    for (int i = 0; i < N; i++) begin
      int gap;
      gap = $urandom_range(0, max_gap);
      repeat (gap) @(negedge clk);
      drive_beat(va[i], vb[i]);
    end
    exp_q.push_back(exp_v);
    // First CLEAR cycle: MAC reset pulse, plus a stray pulse to be ignored.
    check("mac_reset_first_clear", mac_reset, 1);
    stray = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    check("mac_reset_one_cycle", mac_reset, 0);
    if (junk) begin
      for (int c = 0; c < CLR_WAIT + N + 4; c++) begin
        s_valid = 1'b1;
        s_a     = WIDTH'($urandom);
        s_b     = WIDTH'($urandom);
        @(negedge clk);
        check("s_ready_low_while_busy", s_ready, 0);
      end
      s_valid = 1'b0;
    end
  endtask

  task automatic wait_result();
    int t = 0;
    while (exp_q.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("result_within_budget", exp_q.size(), 0);
  endtask

  task automatic wait_signal_mvalid();
    int t = 0;
    while (!m_valid && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("m_valid_arrives", m_valid, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t a1, b1, a2, b2, ap, bp, an, bn, am, bm, ax, bx, ar, br;
    logic [FW-1:0]    held;
    logic [WIDTH-1:0] r;

    a1 = '{1, 2, 3, 4};             b1 = '{5, 6, 7, 8};
    a2 = '{-1, -1, -1, -1};         b2 = '{3, 3, 3, 3};
    ap = '{8191, 8191, 8191, 8191}; bp = '{8191, 8191, 8191, 8191};
    an = '{-8192, -8192, -8192, -8192};
    bn = '{8191, 8191, 8191, 8191};
    am = '{8191, -8192, 8191, -8192};
    bm = '{8191, 8191, 8191, 8191};
    ax = '{8191, 8191, 8191, -8192};
    bx = '{8191, 8191, 8191, 8191};

    reset   = 1'b1;
    s_valid = 1'b0;
    s_a     = '0;
    s_b     = '0;
    m_ready = 1'b1;
    stray   = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_mac_reset", mac_reset, 1);
    check("rst_s_ready", s_ready, 0);
    check("rst_mac_valid_in", mac_valid_in, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_data", m_data, 0);
    check("rst_mac_a", mac_a, 0);
    check("rst_mac_b", mac_b, 0);
    reset = 1'b0;
    @(negedge clk);
    check("load_after_reset", s_ready, 1);

    // Basic dot product, then a second pair proving the MAC is cleared between pairs.
    send_vec(a1, b1, 0, 1'b0, 70);
    wait_result();
    send_vec(a2, b2, 0, 1'b0, -12);
    wait_result();

    // Saturation at both rails, no clamp on alternating signs, and order-dependent clamp.
    send_vec(ap, bp, 0, 1'b0, SAT_MAX);
    wait_result();
    send_vec(an, bn, 0, 1'b0, SAT_MIN);
    wait_result();
    send_vec(am, bm, 0, 1'b0, -16382);
    wait_result();
    send_vec(ax, bx, 0, 1'b0, 67117055);
    wait_result();

    // Back-pressure: result held stable, input closed, until m_ready.
    for (int i = 0; i < N; i++) begin
      r = WIDTH'($urandom); ar[i] = int'($signed(r));
      r = WIDTH'($urandom); br[i] = int'($signed(r));
    end
    m_ready = 1'b0;
    send_vec(ar, br, 0, 1'b0, ref_dot(ar, br));
    wait_signal_mvalid();
    held = m_data;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("bp_m_data_stable", m_data, held);
      check("bp_m_valid_held", m_valid, 1);
      check("bp_s_ready_low", s_ready, 0);
    end
    m_ready = 1'b1;
    @(negedge clk);
    check("bp_s_ready_after_handshake", s_ready, 1);
    check("bp_m_valid_dropped", m_valid, 0);
    wait_result();

    // Gapped random input with extra s_valid beats offered while busy.
    for (int v = 0; v < 6; v++) begin
      for (int i = 0; i < N; i++) begin
        r = WIDTH'($urandom); ar[i] = int'($signed(r));
        r = WIDTH'($urandom); br[i] = int'($signed(r));
      end
      send_vec(ar, br, 3, 1'b1, ref_dot(ar, br));
      wait_result();
    end

    // Reset in the middle of STREAM discards the vector; the next one is clean.
    send_vec(a1, b1, 0, 1'b0, 70);
    begin
      int t = 0;
      while (!mac_valid_in && t < 100) begin
        @(negedge clk);
        t++;
      end
      check("reached_stream", mac_valid_in, 1);
    end
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("midrst_mac_reset", mac_reset, 1);
    check("midrst_m_valid", m_valid, 0);
    check("midrst_s_ready", s_ready, 0);
    check("midrst_mac_valid_in", mac_valid_in, 0);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_back_in_load", s_ready, 1);
    check("midrst_mac_reset_released", mac_reset, 0);
    send_vec(a2, b2, 0, 1'b0, -12);
    wait_result();

    // Reset while a result is pending drops it.
    m_ready = 1'b0;
    send_vec(a1, b1, 0, 1'b0, 70);
    wait_signal_mvalid();
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("pendrst_m_valid", m_valid, 0);
    m_ready = 1'b1;
    reset   = 1'b0;
    @(negedge clk);
    send_vec(a1, b1, 0, 1'b0, 70);
    wait_result();

    repeat (5) @(negedge clk);
    check("no_leftover_results", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
